// File: rtl/lorenz_stepper_if.sv
// Control/status bundle for the Lorenz stepper.
// The master drives the run request and seed state; the slave returns the trajectory.
interface lorenz_stepper_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic                    start;
   logic                    stop;
   logic signed [WIDTH-1:0] x0;
   logic signed [WIDTH-1:0] y0;
   logic signed [WIDTH-1:0] z0;
   logic [CNT_W-1:0]        n_steps;
   logic signed [WIDTH-1:0] x;
   logic signed [WIDTH-1:0] y;
   logic signed [WIDTH-1:0] z;
   logic                    valid;
   logic                    busy;
   logic                    done;
   logic                    sat_flag;

   modport master (
      output start, stop, x0, y0, z0, n_steps,
      input  x, y, z, valid, busy, done, sat_flag
   );

   modport slave (
      input  start, stop, x0, y0, z0, n_steps,
      output x, y, z, valid, busy, done, sat_flag
   );
endinterface

// File: rtl/lorenz_stepper.sv
// Fixed-point forward-Euler integrator for the Lorenz system.
// One shared multiplier; a step takes four product cycles plus one commit.
module lorenz_stepper #(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 8,
   parameter int DT_SHIFT = 6,
   parameter int SIGMA    = 2560,
   parameter int RHO      = 7168,
   parameter int BETA     = 683,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             rst,
   lorenz_stepper_if.slave bus
);
   localparam int DW = WIDTH + 1;
   localparam int PW = 2 * WIDTH + 2;
   localparam int SW = PW + 2;

   localparam logic signed [WIDTH-1:0] SIG_Q = WIDTH'(SIGMA);
   localparam logic signed [WIDTH-1:0] RHO_Q = WIDTH'(RHO);
   localparam logic signed [WIDTH-1:0] BET_Q = WIDTH'(BETA);
   localparam logic signed [SW-1:0] MAXV =
      {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   typedef enum logic [2:0] {
      IDLE, M0, M1, M2, M3, UPD
   } state_t;

   state_t state, state_nx;

   logic signed [WIDTH-1:0] xr, yr, zr;
   logic signed [PW-1:0]    p0, p1, p2, p3;
   logic [CNT_W-1:0]        cnt, nsr, cnt_inc;
   logic                    valid_r, done_r, sat_r;
   logic                    acc, fin;

   logic signed [DW-1:0]    xe, ye, ze, ma, mb;
   logic signed [PW-1:0]    prod, prod_sh;
   logic signed [SW-1:0]    dx, dy, dz, nx, ny, nz;
   logic signed [WIDTH-1:0] xn, yn, zn;
   logic                    cx, cy, cz;

   function automatic logic [WIDTH:0] clamp(
      input logic signed [SW-1:0] v
   );
      if (v > MAXV)
         return {1'b1, MAXV[WIDTH-1:0]};
      else if (v < MINV)
         return {1'b1, MINV[WIDTH-1:0]};
      else
         return {1'b0, v[WIDTH-1:0]};
   endfunction

   assign xe = {xr[WIDTH-1], xr};
   assign ye = {yr[WIDTH-1], yr};
   assign ze = {zr[WIDTH-1], zr};

   always_comb begin
      ma = '0;
      mb = '0;
      unique case (state)
         M0: begin
            ma = {SIG_Q[WIDTH-1], SIG_Q};
            mb = ye - xe;
         end
         M1: begin
            ma = xe;
            mb = {RHO_Q[WIDTH-1], RHO_Q} - ze;
         end
         M2: begin
            ma = xe;
            mb = ye;
         end
         M3: begin
            ma = {BET_Q[WIDTH-1], BET_Q};
            mb = ze;
         end
         IDLE, UPD: ;
      endcase
   end

   assign prod    = PW'(ma) * PW'(mb);
   assign prod_sh = prod >>> FRAC;

   // All three derivatives use the pre-step state, so commits are simultaneous.
   assign dx = SW'(p0);
   assign dy = SW'(p1) - SW'(yr);
   assign dz = SW'(p2) - SW'(p3);
   assign nx = SW'(xr) + (dx >>> DT_SHIFT);
   assign ny = SW'(yr) + (dy >>> DT_SHIFT);
   assign nz = SW'(zr) + (dz >>> DT_SHIFT);

   assign {cx, xn} = clamp(nx);
   assign {cy, yn} = clamp(ny);
   assign {cz, zn} = clamp(nz);

   assign cnt_inc = cnt + 1'b1;
   assign fin     = (nsr != '0) && (cnt_inc == nsr);
   assign acc     = (state == IDLE) && bus.start && !bus.stop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (acc) state_nx = M0;
         M0:   state_nx = M1;
         M1:   state_nx = M2;
         M2:   state_nx = M3;
         M3:   state_nx = UPD;
         UPD:  state_nx = fin ? IDLE : M0;
      endcase
      if (state != IDLE && bus.stop)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xr      <= '0;
         yr      <= '0;
         zr      <= '0;
         p0      <= '0;
         p1      <= '0;
         p2      <= '0;
         p3      <= '0;
         cnt     <= '0;
         nsr     <= '0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         if (acc) begin
            xr    <= bus.x0;
            yr    <= bus.y0;
            zr    <= bus.z0;
            nsr   <= bus.n_steps;
            cnt   <= '0;
            sat_r <= 1'b0;
         end else if (!bus.stop) begin
            unique case (state)
               M0: p0 <= prod_sh;
               M1: p1 <= prod_sh;
               M2: p2 <= prod_sh;
               M3: p3 <= prod_sh;
               UPD: begin
                  xr      <= xn;
                  yr      <= yn;
                  zr      <= zn;
                  cnt     <= cnt_inc;
                  valid_r <= 1'b1;
                  done_r  <= fin;
                  sat_r   <= sat_r | cx | cy | cz;
               end
               IDLE: ;
            endcase
         end
      end
   end

   assign bus.x        = xr;
   assign bus.y        = yr;
   assign bus.z        = zr;
   assign bus.valid    = valid_r;
   assign bus.done     = done_r;
   assign bus.sat_flag = sat_r;
   assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_lorenz_stepper.sv
// Directed bench for lorenz_stepper with a queue-based scoreboard.
// Stimulus pushes expected steps; a negedge monitor pops them on valid.
module tb_lorenz_stepper;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
      logic               done;
      logic               sat;
      int                 cyc;
      string              tag;
   } exp_t;

   exp_t q[$];

   lorenz_stepper_if #(.WIDTH(16), .CNT_W(16)) bus ();

   lorenz_stepper dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push(input int sx, input int sy, input int sz,
                       input logic d, input logic s, input int c,
                       input string tag);
      exp_t e;
      e.x    = 16'(sx);
      e.y    = 16'(sy);
      e.z    = 16'(sz);
      e.done = d;
      e.sat  = s;
      e.cyc  = c;
      e.tag  = tag;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "_x"}, bus.x, e.x);
            chk({e.tag, "_y"}, bus.y, e.y);
            chk({e.tag, "_z"}, bus.z, e.z);
            chk({e.tag, "_done"}, bus.done, e.done);
            chk({e.tag, "_sat"}, bus.sat_flag, e.sat);
            chk({e.tag, "_cycle"}, cyc, e.cyc);
         end
      end else if (bus.done) begin
         chk("done_without_valid", 1, 0);
      end
   end

   task automatic do_start(input int sx, input int sy, input int sz,
                           input int n, output int t0);
      @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.x0      = 16'(sx);
      bus.y0      = 16'(sy);
      bus.z0      = 16'(sz);
      bus.n_steps = 16'(n);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      t0 = cyc;
   endtask

   task automatic drain(input string tag, input int max);
      int n = 0;
      while (q.size() != 0 && n < max) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         chk({tag, "_drain_timeout"}, q.size(), 0);
         q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.x0      = '0;
      bus.y0      = '0;
      bus.z0      = '0;
      bus.n_steps = '0;

      #1;
      chk("rst_x", bus.x, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_z", bus.z, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sat", bus.sat_flag, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // zero state is a fixed point
      do_start(0, 0, 0, 3, t0);
      chk("t033_busy", bus.busy, 1);
      push(0, 0, 0, 0, 0, t0 + 5, "t033_s1");
      push(0, 0, 0, 0, 0, t0 + 10, "t033_s2");
      push(0, 0, 0, 1, 0, t0 + 15, "t033_s3");
      drain("t033", 40);
      chk("t033_busy_after", bus.busy, 0);

      do_start(256, 0, 0, 1, t0);
      push(216, 112, 0, 1, 0, t0 + 5, "t034");
      drain("t034", 20);
      chk("t034_busy_after", bus.busy, 0);

      // every axis pushed against a rail
      do_start(32767, -32768, 0, 1, t0);
      push(22527, -17921, -32768, 1, 1, t0 + 5, "t035");
      drain("t035", 20);
      chk("t035_sat_sticky", bus.sat_flag, 1);

      do_start(256, 0, 0, 0, t0);
      push(216, 112, 0, 0, 0, t0 + 5, "t036_s1");
      push(199, 204, 1, 0, 0, t0 + 10, "t036_s2");
      repeat (11) @(posedge clk);
      #1 bus.stop = 1'b1;
      @(posedge clk);
      #1 bus.stop = 1'b0;
      chk("t036_busy_p12", bus.busy, 0);
      @(posedge clk);
      #1;
      chk("t036_busy_p13", bus.busy, 0);
      chk("t036_pending", q.size(), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("t036_hold_x", bus.x, 199);
      chk("t036_hold_y", bus.y, 204);
      chk("t036_hold_z", bus.z, 1);
      q.delete();

      do_start(256, 0, 0, 1, t0);
      push(216, 112, 0, 1, 0, t0 + 5, "t037");
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.x0    = 16'(1000);
      @(posedge clk);
      #1 bus.start = 1'b0;
      drain("t037", 20);
      chk("t037_busy_after", bus.busy, 0);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      bus.x0    = 16'(500);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("t037_startstop_busy", bus.busy, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("t037_startstop_x", bus.x, 216);
      chk("t037_startstop_busy2", bus.busy, 0);

      // reset lands in M2 of the second step
      do_start(256, 0, 0, 2, t0);
      push(216, 112, 0, 0, 0, t0 + 5, "t038_s1");
      repeat (7) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("t038_x", bus.x, 0);
      chk("t038_y", bus.y, 0);
      chk("t038_z", bus.z, 0);
      chk("t038_busy", bus.busy, 0);
      chk("t038_valid", bus.valid, 0);
      chk("t038_done", bus.done, 0);
      chk("t038_sat", bus.sat_flag, 0);
      chk("t038_pending", q.size(), 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      do_start(256, 0, 0, 1, t0);
      push(216, 112, 0, 1, 0, t0 + 5, "t038_rerun");
      drain("t038", 20);
      repeat (5) @(posedge clk);
      #1;
      chk("final_pending", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
